// File: rtl/iq_alloc.sv
// Issue-queue slot allocator: circular free list of IQ slot IDs with a shadow
// occupancy bitmap that flags illegal allocate/free sequences.
`ifndef IqDepth
`define IqDepth 16
`endif

module iq_alloc #(
  parameter int IQ_DEPTH = `IqDepth,
  parameter int IQ       = $clog2(IQ_DEPTH)
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          flush_,
  input  logic          add_entry_,
  output logic [IQ-1:0] dec_iq_id,
  output logic          iq_avail,
  input  logic          issue_e_,
  input  logic [IQ-1:0] issue_iq_id,
  output logic [IQ:0]   free_cnt,
  output logic          alloc_err
);

  logic [IQ-1:0]       fifo [IQ_DEPTH];
  logic [IQ-1:0]       head;
  logic [IQ-1:0]       tail;
  logic [IQ:0]         cnt;
  logic [IQ_DEPTH-1:0] busy;
  logic                err;

  logic alloc_ok;
  logic free_ok;
  logic op_bad;

  // A free of the ID being allocated this cycle sees busy==0 and is dropped.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    alloc_ok = 1'b0;
    free_ok  = 1'b0;
    op_bad   = 1'b0;
    if (!add_entry_) begin
      if (cnt != '0) alloc_ok = 1'b1;
      else           op_bad   = 1'b1;
    end
    if (!issue_e_) begin
      if (busy[issue_iq_id]) free_ok = 1'b1;
      else                   op_bad  = 1'b1;
    end
  end

  // NOTE: the free-list array is reset, not left undefined, because its
  // initial contents define the allocation order after reset and flush.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < IQ_DEPTH; i++) fifo[i] <= IQ'(i);
      head <= '0;
      tail <= '0;
      cnt  <= (IQ+1)'(IQ_DEPTH);
      busy <= '0;
      err  <= 1'b0;
    end else if (!flush_) begin
      for (int i = 0; i < IQ_DEPTH; i++) fifo[i] <= IQ'(i);
      head <= '0;
      tail <= '0;
      cnt  <= (IQ+1)'(IQ_DEPTH);
      busy <= '0;
      err  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (alloc_ok) begin
        busy[fifo[head]] <= 1'b1;
        head             <= head + 1'b1;
      end
      if (free_ok) begin
        fifo[tail]        <= issue_iq_id;
        tail              <= tail + 1'b1;
        busy[issue_iq_id] <= 1'b0;
      end
      if (alloc_ok && !free_ok)      cnt <= cnt - 1'b1;
      else if (free_ok && !alloc_ok) cnt <= cnt + 1'b1;
      if (op_bad) err <= 1'b1;
    end
  end

  assign dec_iq_id = fifo[head];
  assign iq_avail  = (cnt != '0);
  assign free_cnt  = cnt;
  assign alloc_err = err;

endmodule

// File: doc/iq_alloc.md
# iq_alloc

Issue-queue slot allocator sitting between rename/dispatch and `inst_sched`. It keeps a circular FIFO of free IQ slot IDs and presents the next free ID as `dec_iq_id` to dispatch. It consumes a slot on `add_entry_` and returns the slot when `inst_sched` issues it (`issue_e_`, `issue_iq_id`). A shadow occupancy bitmap detects illegal allocate/free sequences.

## Interface
- `IQ_DEPTH`, default `` `IqDepth ``: number of IQ slots; a power of two, ≥ 2.
- `IQ`, default `$clog2(IQ_DEPTH)`: slot ID width.
- `clk` in 1: clock; all state updates on posedge.
- `reset_` in 1: reset, asynchronous, active-low.
- `flush_` in 1: synchronous, active-low; returns every slot to the free list.
- `add_entry_` in 1: active-low; dispatch consumes `dec_iq_id` this cycle.
- `dec_iq_id` out IQ: next free slot ID (FIFO head); valid while `iq_avail` is high.
- `iq_avail` out 1: high when free count > 0; dispatch stalls when low.
- `issue_e_` in 1: active-low; `inst_sched` frees `issue_iq_id`.
- `issue_iq_id` in IQ: slot being freed.
- `free_cnt` out IQ+1: number of free slots.
- `alloc_err` out 1: sticky error flag.

## Operation
- State:
  - `fifo[IQ_DEPTH]` of IQ-bit IDs.
  - `head`, `tail`: IQ bits each; they wrap naturally modulo `IQ_DEPTH`.
  - `cnt`: IQ+1 bits.
  - `busy[IQ_DEPTH]`: occupancy bitmap.
  - `err`: sticky error bit.
- Reset (async) and flush (sync, `flush_` low at posedge) both load:
  - `fifo[i]=i`, `head=0`, `tail=0`, `cnt=IQ_DEPTH`, `busy=0`, `err=0`.
- Flush has priority over `add_entry_` and `issue_e_` in the same cycle; both are ignored.
- Allocate: `add_entry_` low and `cnt>0`:
  - `busy[fifo[head]]<=1`, `head<=head+1`.
- Free: `issue_e_` low and `busy[issue_iq_id]==1`:
  - `fifo[tail]<=issue_iq_id`, `tail<=tail+1`, `busy[issue_iq_id]<=0`.
- Count:
  - `cnt` +1 on a lone valid free, −1 on a lone valid allocate.
  - Unchanged when both are valid in the same cycle (head and tail both advance).
- Same-ID allocate and free in one cycle: the alloc'd ID (head) and the freed ID must differ. If they are equal, the free is illegal because `busy` is still 0; it is dropped and sets `err`.
- Error conditions set `err<=1`, which holds until reset or flush. FIFO and busy state are left untouched, i.e. the offending operation is dropped:
  - `add_entry_` low while `cnt==0`.
  - `issue_e_` low with `busy[issue_iq_id]==0` (double free, or free of a never-allocated slot).
- No bypass: a slot freed in cycle N can appear on `dec_iq_id` no earlier than cycle N+1, and only after all older free IDs ahead of it.
- Outputs are combinational from registers only:
  - `dec_iq_id=fifo[head]`.
  - `iq_avail=(cnt!=0)`.
  - `free_cnt=cnt`.
  - `alloc_err=err`.
- No input→output combinational paths.
- Reset values:
  - `dec_iq_id=0`, `iq_avail=1`, `free_cnt=IQ_DEPTH`, `alloc_err=0`.

## Timing
- Allocate latency: `dec_iq_id` advances to the next ID at the posedge that samples `add_entry_` low. Back-to-back allocation every cycle is supported.
- Free latency: 1 cycle to re-enter the list; `free_cnt` and `iq_avail` update at that same posedge.
- Full → empty: after `IQ_DEPTH` consecutive allocations `iq_avail` falls at the posedge of the last one.
  - A simultaneous free in that cycle keeps `cnt=1` and `iq_avail` high.
- Empty with a simultaneous allocate and free: the allocate is an error (`cnt==0` is sampled), and the free still completes. The next cycle shows `cnt=1` with `err` set.
- Wrap-around: `head` and `tail` roll over from `IQ_DEPTH-1` to 0 with no bubble.
- Reset asserted mid-operation clears state immediately, without waiting for a clock. The first allocate after deassertion returns ID 0.

## Test plan (IQ_DEPTH=16)
- **Reset:** assert `reset_`, release.
  - Expect `dec_iq_id=0`, `iq_avail=1`, `free_cnt=16`, `alloc_err=0`.
- **Fill:** 16 consecutive `add_entry_`.
  - Expect `dec_iq_id` sequence 0..15, then `iq_avail=0`, `free_cnt=0`.
  - A 17th `add_entry_` sets `alloc_err=1` with `free_cnt` staying 0.
- **Out-of-order free:** from full allocation, free ID 5, then ID 2, then ID 9 in separate cycles.
  - Expect `free_cnt=3`.
  - Next three allocates return 5, 2, 9; `iq_avail=0` after the third.
- **Simultaneous alloc/free and wrap:** from reset, allocate 14. Then for 6 cycles allocate while freeing IDs 0..5.
  - Expect allocates return 14, 15, 0, 1, 2, 3; `free_cnt` stays 2; no error.
- **Double free:** allocate ID 0, free 0, free 0 again.
  - Expect `alloc_err=1` after the second free, and `free_cnt=16` (not 17).
  - Freeing never-allocated ID 7 after reset also sets `alloc_err`.
- **Flush:** allocate 10, then assert `flush_` with `issue_e_` low on ID 3 in the same cycle.
  - Next cycle expect `free_cnt=16`, `dec_iq_id=0`, `alloc_err=0`, and allocation order 0, 1, 2… restored.
